alu_serial_responder: RTL and testbench



---
 rtl/alu_serial_responder_if.sv | 28 ++
 rtl/alu_serial_responder.sv | 139 +++++++++++++
 tb/tb_alu_serial_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_responder_if.sv
// Request/response bus for the slice-serial ALU responder.
interface alu_serial_responder_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_cmd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carryout;
  logic             rsp_overflow;
  logic             rsp_zero;

  // Requester side
  modport master (
    output req_valid, req_a, req_b, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );

  // Responder side
  modport slave (
    input  req_valid, req_a, req_b, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_serial_responder.sv
// Slice-serial ALU responder: accepts one request, computes SLICE bits per
// clock LSB first, then holds the result and flags until the consumer takes it.
module alu_serial_responder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_serial_responder_if.slave  bus
);
  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       cmd_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             co_q, ov_q, zero_q;

  logic [IW-1:0]    base;
  logic [SLICE-1:0] a_s, b_s, b_eff, slice_res;
  logic [SLICE:0]   sum;
  logic             is_sub, is_arith, last;
  logic             c_msb, c_in_msb, ov_arith, slt_bit;
  logic [WIDTH-1:0] res_full;

  // Slice datapath and the full result as it would look after this edge
  always_comb begin
    base      = IW'(32'(cnt_q) * SLICE);
    a_s       = a_q[base +: SLICE];
    b_s       = b_q[base +: SLICE];
    is_sub    = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    is_arith  = is_sub || (cmd_q == CMD_ADD);
    b_eff     = is_sub ? ~b_s : b_s;
    sum       = {1'b0, a_s} + {1'b0, b_eff} + (SLICE+1)'(carry_q);
    slice_res = '0;
    case (cmd_q)
      CMD_ADD, CMD_SUB, CMD_SLT: slice_res = sum[SLICE-1:0];
      CMD_XOR:                   slice_res = a_s ^ b_s;
      CMD_AND:                   slice_res = a_s & b_s;
      CMD_NAND:                  slice_res = ~(a_s & b_s);
      CMD_NOR:                   slice_res = ~(a_s | b_s);
      CMD_OR:                    slice_res = a_s | b_s;
      default:                   slice_res = '0;
    endcase
    // Carry into the top bit recovered from the top bit's sum equation
    c_msb    = sum[SLICE];
    c_in_msb = a_s[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
    ov_arith = c_msb ^ c_in_msb;
    slt_bit  = sum[SLICE-1] ^ ov_arith;
    last     = (cnt_q == CW'(N - 1));
    res_full = res_q;
    if (cmd_q == CMD_SLT) res_full = WIDTH'(slt_bit);
    else                  res_full[base +: SLICE] = slice_res;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = BUSY;
      BUSY:    if (last)          state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, slice accumulation and flag resolution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= CMD_ADD;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            cmd_q   <= bus.req_cmd;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= (bus.req_cmd == CMD_SUB) || (bus.req_cmd == CMD_SLT);
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
          end
        end
        BUSY: begin
          if (is_arith) carry_q <= c_msb;
          if (last) begin
            cnt_q  <= '0;
            res_q  <= res_full;
            co_q   <= is_arith && (cmd_q != CMD_SLT) && c_msb;
            ov_q   <= is_arith && (cmd_q != CMD_SLT) && ov_arith;
            zero_q <= (res_full == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
            res_q[base +: SLICE] <= slice_res;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decoded from the state register
  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == DONE);
  assign bus.rsp_result   = res_q;
  assign bus.rsp_carryout = co_q;
  assign bus.rsp_overflow = ov_q;
  assign bus.rsp_zero     = zero_q;
endmodule

// File: tb/tb_alu_serial_responder.sv
// Scoreboard bench for alu_serial_responder: directed corner cases, random
// operations, backpressure and asynchronous reset mid-operation.
module tb_alu_serial_responder;
  localparam int unsigned W = 32;
  localparam int unsigned S = 4;
  localparam int unsigned N = W / S;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high
  rsp_t exp_q[$];

  alu_serial_responder_if #(.WIDTH(W)) bus ();

  alu_serial_responder #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: full-width arithmetic straight from the command table
  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cmd);
    rsp_t       r;
    logic [W:0] full;
    r = '0;
    case (cmd)
      3'd0: begin
        full = {1'b0, a} + {1'b0, b};
        r.res = full[W-1:0];
        r.co  = full[W];
        r.ov  = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      3'd1: begin
        full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r.res = full[W-1:0];
        r.co  = full[W];
        r.ov  = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      3'd2: r.res = a ^ b;
      3'd3: r.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd4: r.res = a & b;
      3'd5: r.res = ~(a & b);
      3'd6: r.res = ~(a | b);
      default: r.res = a | b;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Consumer ready, changed away from the sampling points
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pop and compare on every completed response handshake
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got result 0x%0h with no request outstanding", bus.rsp_result);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 64'({bus.rsp_result, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero}), 64'(e));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cmd, input bit push);
    int t;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 64'(bus.req_ready), 64'(1));
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cmd   = cmd;
    @(posedge clk);
    if (push) exp_q.push_back(model(a, b, cmd));
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = W'($urandom);
    bus.req_b     = W'($urandom);
    bus.req_cmd   = 3'($urandom);
    check("req_ready_after_accept", 64'(bus.req_ready), 64'(0));
  endtask

  // Cycles from the accept edge until rsp_valid is seen
  task automatic wait_rsp();
    int lat;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) break;
      lat++;
    end
    check("latency", 64'(lat), 64'(N));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  logic [W-1:0] da [12] = '{32'd2, 32'd5, 32'd4, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hF0F0_1234, 32'hFFFF_0000, 32'h0000_00FF};
  logic [W-1:0] db [12] = '{32'd1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd1, 32'd5, 32'd1,
                            32'd1, 32'h7FFF_FFFF, 32'd0, 32'h0F0F_1234, 32'h00FF_FF00, 32'hFFFF_FF00};
  logic [2:0]   dc [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1,
                            3'd3, 3'd3, 3'd6, 3'd2, 3'd4, 3'd5};

  logic [W+2:0] snap;

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cmd   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_outputs", 64'({bus.rsp_result, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero}), 64'(0));
    check("reset_req_ready", 64'(bus.req_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send(da[i], db[i], dc[i], 1'b1);
      wait_rsp();
    end

    for (int i = 0; i < 40; i++) begin
      send(pick(), pick(), 3'($urandom_range(0, 7)), 1'b1);
      wait_rsp();
    end

    // Backpressure: response must hold for 20 cycles, then hand off on a pulse
    drain();
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h0F0F_0F0F, 3'd0, 1'b1);
    wait_rsp();
    snap = {bus.rsp_result, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_stable", 64'({bus.rsp_result, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero}), 64'(snap));
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("bp_req_ready", 64'(bus.req_ready), 64'(0));
    end
    rdy_mode = 2;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("bp_release_req_ready", 64'(bus.req_ready), 64'(1));
    check("bp_release_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    rdy_mode = 0;

    // Asynchronous reset in the third BUSY cycle discards the operation
    drain();
    send(32'h0000_0003, 32'h0000_0004, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("arst_outputs", 64'({bus.rsp_result, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero}), 64'(0));
    check("arst_req_ready", 64'(bus.req_ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd1, 32'd1, 3'd0, 1'b1);
    wait_rsp();

    drain();
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
